// File: rtl/serial_frame_rx_if.sv
// Bundle between the upstream flip-flop stage and the frame receiver.
// valid is a one-cycle pulse with no ready: the consumer must take data_out/par_err that cycle.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              d_in;
  logic              en;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              par_err;
  logic              busy;
  logic [1:0]        fsm_state;

  modport master (
    output d_in,
    output en,
    input  data_out,
    input  valid,
    input  par_err,
    input  busy,
    input  fsm_state
  );

  modport slave (
    input  d_in,
    input  en,
    output data_out,
    output valid,
    output par_err,
    output busy,
    output fsm_state
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, collects DATA_W bits LSB-first,
// then checks a trailing even-parity bit and emits the word with a one-cycle valid.
module serial_frame_rx #(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  serial_frame_rx_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SYNC_W-1:0] win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              perr_q;
  logic              done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      win_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      valid_q <= done;
      perr_q  <= done & (^shreg_q ^ bus.d_in);
      if (done) begin
        data_q <= shreg_q;
      end
    end
  end

  // With en low every next-value equals the current one and done stays 0,
  // which both holds the datapath and forces valid/par_err low.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    if (bus.en) begin
      case (state_q)
        HUNT: begin
          win_d = {win_q[SYNC_W-2:0], bus.d_in};
          if (win_d == SYNC) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d[cnt_q] = bus.d_in;
          cnt_d          = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          // The parity bit is not fed into the window, so hunting restarts empty.
          done    = 1'b1;
          state_d = HUNT;
          win_d   = '0;
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.par_err   = perr_q;
  assign bus.busy      = (state_q != HUNT);
  assign bus.fsm_state = state_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: drivers push expected frames into a queue,
// a negedge monitor pops and compares whenever valid is seen.
module tb_serial_frame_rx;
  localparam int DATA_W = 8;

  logic clk;
  logic rst;

  serial_frame_rx_if #(.DATA_W(DATA_W)) bus ();

  serial_frame_rx #(.DATA_W(DATA_W), .SYNC_W(4), .SYNC(4'b1011)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard queues: {par_err, data}, the cycle valid must appear in, busy length
  logic [DATA_W:0] exp_q[$];
  int              exp_cyc_q[$];
  int              exp_busy_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // driver tasks
  task automatic send_bit(input logic b, input logic e);
    @(negedge clk);
    bus.d_in = b;
    bus.en   = e;
    @(posedge clk);
    #1;
  endtask

  // gated=1 inserts a disabled edge with junk d_in after each enabled bit
  task automatic send_bit_g(input logic b, input bit gated);
    send_bit(b, 1'b1);
    if (gated) send_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic par, input bit gated);
    logic [3:0] sync;
    logic [DATA_W:0] exp;
    sync = 4'b1011;
    for (int i = 3; i >= 0; i--) send_bit_g(sync[i], gated);
    for (int i = 0; i < DATA_W; i++) send_bit_g(data[i], gated);
    exp = {(^data) ^ par, data};
    exp_q.push_back(exp);
    exp_busy_q.push_back(gated ? 2 * (DATA_W + 1) : DATA_W + 1);
    send_bit(par, 1'b1);
    exp_cyc_q.push_back(cyc);
    if (gated) send_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0, 1'b1);
  endtask

  // monitor
  logic prev_valid = 1'b0;
  int   busy_run   = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid) begin
        check("valid_single_cycle", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [DATA_W:0] e;
          e = exp_q.pop_front();
          check("data_out", 32'(bus.data_out), 32'(e[DATA_W-1:0]));
          check("par_err", 32'(bus.par_err), 32'(e[DATA_W]));
          check("valid_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
          check("busy_length", 32'(busy_run), 32'(exp_busy_q.pop_front()));
        end
        busy_run = 0;
      end else begin
        check("par_err_idle", 32'(bus.par_err), 32'd0);
        busy_run = bus.busy ? busy_run + 1 : 0;
      end
      prev_valid = bus.valid;
    end else begin
      prev_valid = 1'b0;
      busy_run   = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [DATA_W-1:0] tbl_data[3] = '{8'h00, 8'hFF, 8'h01};
  logic              tbl_par [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    rst      = 1'b1;
    bus.d_in = 1'b0;
    bus.en   = 1'b1;
    // 1: reset with d_in toggling
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.d_in = ~bus.d_in;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.d_in = 1'b0;
    #1;
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_par_err", 32'(bus.par_err), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    idle(2);

    // 2: good frame, 3: parity error
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(3);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(3);

    // 4: enable gating
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(3);

    // 5: reset mid-frame, then a clean frame
    send_bit(1, 1); send_bit(0, 1); send_bit(1, 1); send_bit(1, 1);
    send_bit(1, 1); send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
    check("busy_mid_frame", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_data_out", 32'(bus.data_out), 32'd0);
    check("abort_valid", 32'(bus.valid), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(3);
    check("data_out_hold", 32'(bus.data_out), 32'h3C);

    // 6: overlapping partial sync (1,0 then 1,0,1,1) and sync inside data
    send_bit(1, 1);
    send_bit(0, 1);
    send_frame(8'hDB, 1'b0, 1'b0);
    idle(3);

    // extra boundary vectors: all zeros, all ones with bad parity, single bit
    for (int i = 0; i < 3; i++) begin
      send_frame(tbl_data[i], tbl_par[i], 1'b0);
      idle(1);
    end
    // back-to-back frames with no idle gap
    send_frame(8'h5A, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(4);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
